// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared code and segment-pattern constants for the 7-segment scan driver
// Purpose: digit-code type, special code values and logical segment patterns
//          ({a,b,c,d,e,f,g,dp}, 1 = lit) used by seg_decode and seg_scan_driver.
// Ports:   none (package).
package seg_pkg;

  typedef logic [4:0] digit_t;

  localparam digit_t CODE_MINUS = 5'h10;
  localparam digit_t CODE_BLANK = 5'h11;

  localparam logic [7:0] SEG_MINUS = 8'b0000_0010;
  localparam logic [7:0] SEG_OFF   = 8'b0000_0000;
  localparam logic [7:0] SEG_LAMP  = 8'b1111_1111;

  // Hex glyphs 0..F, dp bit always 0 here; the digit's dp is OR'd in later.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'b1111_1100, 8'b0110_0000, 8'b1101_1010, 8'b1111_0010,
    8'b0110_0110, 8'b1011_0110, 8'b1011_1110, 8'b1110_0000,
    8'b1111_1110, 8'b1111_0110, 8'b1110_1110, 8'b0011_1110,
    8'b1001_1100, 8'b0111_1010, 8'b1001_1110, 8'b1000_1110
  };

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational digit code to logical segment pattern
// Purpose: maps a 5-bit display code to {a,b,c,d,e,f,g,dp} with 1 = lit.
// Ports:   code    in  5  display code (0x00-0x0F hex, 0x10 minus, 0x11 blank, else lamp test)
//          pattern out 8  logical segment pattern, dp bit always 0
module seg_decode
  import seg_pkg::*;
(
  input  digit_t      code,
  output logic [7:0]  pattern
);

  always_comb begin
    if (!code[4]) begin
      pattern = HEX_SEG[code[3:0]];
    end else if (code == CODE_MINUS) begin
      pattern = SEG_MINUS;
    end else if (code == CODE_BLANK) begin
      pattern = SEG_OFF;
    end else begin
      pattern = SEG_LAMP;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scan driver with double buffering and blink
// Purpose: time-multiplexes per-digit codes onto a shared segment bus with one-hot
//          anode select; frame-synchronous commit of loaded data, per-digit blank/blink,
//          and a dead time at the start of every slot to suppress ghosting.
// Ports:   clk, rst          clock, synchronous active-high reset
//          load              strobe capturing code_in/dp_in/en_mask/blink_mask into pending
//          code_in[5*DIGITS] digit k at [5k+4:5k]
//          dp_in, en_mask, blink_mask [DIGITS]  per-digit dp, enable, blink
//          seg_out[8]        {a..g,dp} at pin polarity
//          an_out[DIGITS]    one-hot anode at pin polarity
//          frame_start       pulse on first cycle of digit 0 slot
//          load_ack          pulse when pending data became active
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DIV            = 100000,
  parameter int DEAD           = 2,
  parameter int BLINK_FRAMES   = 32,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [5*DIGITS-1:0]   code_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_start,
  output logic                  load_ack
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Pin-level inversion masks, applied only at the output registers.
  localparam logic [7:0]        SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         fcnt;
  logic                  phase;

  logic [5*DIGITS-1:0]   pend_code, act_code;
  logic [DIGITS-1:0]     pend_dp, pend_en, pend_blink;
  logic [DIGITS-1:0]     act_dp, act_en, act_blink;
  logic                  pend_valid;

  logic                  slot_end, frame_end;
  digit_t                cur_code;
  logic [7:0]            cur_pat;
  logic                  shown, lit;
  logic [7:0]            seg_log;
  logic [DIGITS-1:0]     an_log;

  assign slot_end  = (cnt == CW'(DIV - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

  always_comb begin
    cur_code = act_code[5*int'(idx) +: 5];
    shown    = act_en[idx] && !(act_blink[idx] && phase);
    // Dead time: the first DEAD cycles of each slot keep every anode off.
    lit      = shown && (int'(cnt) >= DEAD);
    seg_log  = lit ? (cur_pat | {7'b0, act_dp[idx]}) : 8'h00;
    an_log   = lit ? (DIGITS'(1) << idx) : '0;
  end

  seg_decode u_decode (
    .code    (cur_code),
    .pattern (cur_pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      phase       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_code   <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_blink  <= '0;
      act_code    <= {DIGITS{CODE_BLANK}};
      act_dp      <= '0;
      act_en      <= '0;
      act_blink   <= '0;
      seg_out     <= SEG_XOR;
      an_out      <= AN_XOR;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      seg_out     <= seg_log ^ SEG_XOR;
      an_out      <= an_log ^ AN_XOR;
      frame_start <= frame_end;
      load_ack    <= frame_end && pend_valid;

      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (frame_end) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
        // Commit takes the pending contents from before this edge, so a load
        // landing on the boundary waits for the next frame.
        if (pend_valid) begin
          act_code  <= pend_code;
          act_dp    <= pend_dp;
          act_en    <= pend_en;
          act_blink <= pend_blink;
        end
      end

      if (load) begin
        pend_code  <= code_in;
        pend_dp    <= dp_in;
        pend_en    <= en_mask;
        pend_blink <= blink_mask;
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int DEAD   = 1;
  localparam int BF     = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [19:0] code_in = '0;
  logic [3:0]  dp_in = '0, en_mask = '0, blink_mask = '0;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_start, load_ack;

  seg_scan_driver #(
    .DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .code_in(code_in), .dp_in(dp_in),
    .en_mask(en_mask), .blink_mask(blink_mask), .seg_out(seg_out), .an_out(an_out),
    .frame_start(frame_start), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: n = cycles since reset release; slot/digit/frame/phase derive from n.
  int          n = 0;
  logic [19:0] a_code = {4{5'h11}};
  logic [3:0]  a_dp = '0, a_en = '0, a_bl = '0;
  logic [19:0] p_code = '0;
  logic [3:0]  p_dp = '0, p_en = '0, p_bl = '0;
  logic        p_valid = 1'b0;

  function automatic logic [7:0] ref_seg(input logic [4:0] c);
    logic [7:0] t [16];
    t = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
          8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    if (c < 5'd16)       return t[c[3:0]];
    else if (c == 5'h10) return 8'h02;
    else if (c == 5'h11) return 8'h00;
    else                 return 8'hFF;
  endfunction

  task automatic expect_pins(output logic [7:0] es, output logic [3:0] ea);
    int p, cn, id, ph;
    logic shown;
    p  = n % FRAME;
    cn = p % DIV;
    id = p / DIV;
    ph = ((n / FRAME) / BF) % 2;
    shown = a_en[id] && !(a_bl[id] && (ph == 1));
    if (cn < DEAD || !shown) begin
      es = 8'h00;
      ea = 4'h0;
    end else begin
      es = ref_seg(a_code[5*id +: 5]) | {7'b0, a_dp[id]};
      ea = 4'(1 << id);
    end
    es = ~es;
    ea = ~ea;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got %h exp %h", tag, n, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [19:0] c,
                      input logic [3:0] d, input logic [3:0] e, input logic [3:0] b);
    logic [7:0] es;
    logic [3:0] ea;
    logic efs, eack, bnd;
    rst = r; load = ld; code_in = c; dp_in = d; en_mask = e; blink_mask = b;
    bnd = 1'b0;
    if (r) begin
      es = 8'hFF; ea = 4'hF; efs = 1'b0; eack = 1'b0;
    end else begin
      expect_pins(es, ea);
      bnd  = ((n % FRAME) == FRAME - 1);
      efs  = bnd;
      eack = bnd && p_valid;
    end
    @(posedge clk);
    if (r) begin
      n = 0; a_code = {4{5'h11}}; a_dp = '0; a_en = '0; a_bl = '0; p_valid = 1'b0;
    end else begin
      if (bnd && p_valid) begin
        a_code = p_code; a_dp = p_dp; a_en = p_en; a_bl = p_bl;
      end
      if (ld) begin
        p_code = c; p_dp = d; p_en = e; p_bl = b; p_valid = 1'b1;
      end else if (bnd) begin
        p_valid = 1'b0;
      end
      n++;
    end
    #1;
    check("seg_out", seg_out, es);
    check("an_out", {4'b0, an_out}, {4'b0, ea});
    check("frame_start", {7'b0, frame_start}, {7'b0, efs});
    check("load_ack", {7'b0, load_ack}, {7'b0, eack});
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 20'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic seek(input int pos);
    for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) idle(1);
  endtask

  initial begin
    // Reset, including a load asserted together with rst (must be ignored).
    step(1'b1, 1'b0, 20'h0, 4'h0, 4'h0, 4'h0);
    step(1'b1, 1'b1, 20'hFFFFF, 4'hF, 4'hF, 4'hF);
    idle(40);

    // Mid-frame load of {3,2,1,0}, dp on digit 2.
    seek(8);
    step(1'b0, 1'b1, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0100, 4'b1111, 4'b0000);
    idle(40);

    // Special codes and a blanked digit.
    step(1'b0, 1'b1, {5'h1F, 5'h11, 5'h10, 5'h05}, 4'b0000, 4'b1011, 4'b0000);
    idle(40);

    // Blink on digit 0.
    step(1'b0, 1'b1, {5'h08, 5'h08, 5'h08, 5'h08}, 4'b0001, 4'b1111, 4'b0001);
    idle(100);

    // Two loads in one frame: the second wins.
    seek(2);
    step(1'b0, 1'b1, {5'h0A, 5'h0B, 5'h0C, 5'h0D}, 4'b1111, 4'b1111, 4'b0000);
    idle(3);
    step(1'b0, 1'b1, {5'h04, 5'h05, 5'h06, 5'h07}, 4'b0010, 4'b1111, 4'b0000);
    idle(20);

    // Load on the frame-boundary edge commits one frame later.
    seek(FRAME - 1);
    step(1'b0, 1'b1, {5'h0E, 5'h0F, 5'h10, 5'h09}, 4'b1000, 4'b0111, 4'b0000);
    idle(40);

    // Randomized loads.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        step(1'b0, 1'b1, 20'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      else
        idle(1);
    end

    // Reset mid-slot with a pending load.
    seek(6);
    step(1'b0, 1'b1, {5'h01, 5'h01, 5'h01, 5'h01}, 4'hF, 4'hF, 4'h0);
    idle(2);
    step(1'b1, 1'b1, {5'h02, 5'h02, 5'h02, 5'h02}, 4'hF, 4'hF, 4'h0);
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
